// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - tagged in-order fetch buffer with alloc/fill/pop/flush pointers
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_alloc,
    input  logic [31:0]        i_alloc_pc,
    input  logic               i_fill,
    input  logic [31:0]        i_fill_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output fetch_entry_t       o_head_entry,
    output logic [PTR_W-1:0]   o_occupancy,
    output logic [PTR_W-1:0]   o_outstanding
);

    fetch_entry_t     r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_fill;
    logic [PTR_W-1:0] r_tail;

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_fill_idx;
    logic [IDX_W-1:0] w_tail_idx;

    assign w_head_idx    = r_head[IDX_W-1:0];
    assign w_fill_idx    = r_fill[IDX_W-1:0];
    assign w_tail_idx    = r_tail[IDX_W-1:0];
    assign o_occupancy   = r_tail - r_head;
    assign o_outstanding = r_tail - r_fill;

    // A response landing on an empty head is forwarded in the same cycle.
    always_comb begin
        o_head_entry = r_entries[w_head_idx];
        if (!r_entries[w_head_idx].filled && i_fill && (r_fill == r_head)) begin
            o_head_entry.data   = i_fill_data;
            o_head_entry.filled = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_fill <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (i_flush) begin
            r_head <= r_tail;
            r_fill <= r_tail;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].filled <= 1'b0;
            end
        end else begin
            if (i_alloc) begin
                r_entries[w_tail_idx].pc     <= i_alloc_pc;
                r_entries[w_tail_idx].filled <= 1'b0;
                r_tail                       <= r_tail + 1'b1;
            end
            if (i_fill) begin
                r_entries[w_fill_idx].data   <= i_fill_data;
                r_entries[w_fill_idx].filled <= 1'b1;
                r_fill                       <= r_fill + 1'b1;
            end
            // Pop last so a forwarded entry consumed this cycle ends up empty.
            if (i_pop) begin
                r_entries[w_head_idx].filled <= 1'b0;
                r_head                       <= r_head + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem request channel, redirect and response dropping
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_current_out,
    output logic [31:0] pc_next_out
);

    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int DROP_W = $clog2(2 * DEPTH + 1);
    localparam int SUM_W  = DROP_W + 1;

    logic [31:0]       r_fetch_pc;
    logic [DROP_W-1:0] r_drop_cnt;

    fetch_entry_t      w_head;
    logic [PTR_W-1:0]  w_occupancy;
    logic [PTR_W-1:0]  w_outstanding;
    logic [SUM_W-1:0]  w_inflight;
    logic              w_req_fire;
    logic              w_rsp_drop;
    logic              w_rsp_fill;
    logic              w_pop;
    logic              w_unused_ok;

    assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

    // Dropped-but-pending responses still occupy memory slots, so they gate new requests.
    assign w_inflight     = SUM_W'(r_drop_cnt) + SUM_W'(w_outstanding);
    assign imem_req_valid = !reset && !redirect_valid
                          && (w_occupancy < PTR_W'(DEPTH))
                          && (w_inflight < SUM_W'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

    assign instr_valid     = w_head.filled && !redirect_valid;
    assign w_pop           = instr_valid && !stall;
    assign instruction_out = instr_valid ? w_head.data : 32'h0;
    assign pc_current_out  = instr_valid ? w_head.pc : 32'h0;
    assign pc_next_out     = instr_valid ? (w_head.pc + 32'(INSTR_BYTES)) : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            // Every unanswered request becomes a drop; a response consumed now is no longer pending.
            r_drop_cnt <= r_drop_cnt + DROP_W'(w_outstanding) - DROP_W'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
            end
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk           (clk),
        .rst           (reset),
        .i_alloc       (w_req_fire),
        .i_alloc_pc    (r_fetch_pc),
        .i_fill        (w_rsp_fill),
        .i_fill_data   (imem_rsp_data),
        .i_pop         (w_pop),
        .i_flush       (redirect_valid),
        .o_head_entry  (w_head),
        .o_occupancy   (w_occupancy),
        .o_outstanding (w_outstanding)
    );

    a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> ((r_drop_cnt != '0) || (w_outstanding != '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instruction_out;
    logic [31:0] pc_current_out;
    logic [31:0] pc_next_out;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instruction_out (instruction_out),
        .pc_current_out  (pc_current_out),
        .pc_next_out     (pc_next_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic        erv;
        logic [31:0] eaddr;
    } vec_t;

    pend_t q[$];
    vec_t  tv[20];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    mem_lat = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [31:0] epc);
        check({name, " instr_valid"}, 32'(instr_valid), 32'(ev));
        check({name, " instruction"}, instruction_out, ev ? (epc ^ XOR_KEY) : 32'h0);
        check({name, " pc_current"}, pc_current_out, ev ? epc : 32'h0);
        check({name, " pc_next"}, pc_next_out, ev ? (epc + 32'd4) : 32'h0);
    endtask

    // Memory model: in-order, fixed latency, data = addr ^ XOR_KEY. Call at the negedge.
    task automatic advance();
        if (!reset && imem_req_valid && imem_req_ready) begin
            q.push_back('{imem_req_addr, cyc + mem_lat});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = q[0].addr ^ XOR_KEY;
            void'(q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic expect_stream(input string name, input logic [31:0] first_pc,
                                 input int n, input int budget);
        logic [31:0] exp_pc;
        int          got;
        exp_pc = first_pc;
        got    = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                check({name, " pc"}, pc_current_out, exp_pc);
                check({name, " instr"}, instruction_out, exp_pc ^ XOR_KEY);
                check({name, " pc_next"}, pc_next_out, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            advance();
        end
        if (got < n) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got %0d instructions expected %0d", name, got, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h10};
        tv[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h14};
        tv[6]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
        tv[9]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
        tv[10] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
        tv[11] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h18};
        tv[12] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h1C};
        tv[13] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h20};
        tv[14] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h24};
        tv[15] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h24};
        tv[16] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h24};
        tv[17] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h24};
        tv[18] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h28};
        tv[19] = '{1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 32'h2C};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #2;
        check_out("reset", 1'b0, 32'h0);
        check("reset req_valid", 32'(imem_req_valid), 32'h0);
        check("reset req_addr", imem_req_addr, 32'h0);

        // Zero-wait stream, stall at 0x10, then a ready=0 hold.
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 20; i++) begin
            stall          = tv[i].stall;
            imem_req_ready = tv[i].ready;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), tv[i].ev, tv[i].epc);
            check($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(tv[i].erv));
            check($sformatf("vec%0d req_addr", i), imem_req_addr, tv[i].eaddr);
            advance();
        end

        // Redirect to 0x203 with two requests in flight.
        do_reset();
        mem_lat = 3;
        repeat (2) begin
            @(negedge clk);
            advance();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        @(negedge clk);
        check("rdA req_valid", 32'(imem_req_valid), 32'h0);
        check("rdA instr_valid", 32'(instr_valid), 32'h0);
        advance();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rdA req_addr", imem_req_addr, 32'h0000_0200);
        advance();
        expect_stream("rdA", 32'h0000_0200, 3, 30);

        // Redirect coinciding with a response, then a second redirect.
        do_reset();
        mem_lat = 2;
        repeat (2) begin
            @(negedge clk);
            advance();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        check("rdB1 instr_valid", 32'(instr_valid), 32'h0);
        advance();
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        check("rdB2 instr_valid", 32'(instr_valid), 32'h0);
        advance();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rdB req_valid", 32'(imem_req_valid), 32'h1);
        check("rdB req_addr", imem_req_addr, 32'h0000_0300);
        advance();
        expect_stream("rdB", 32'h0000_0300, 3, 30);

        // Asynchronous reset with a full buffer, then refetch from RESET_PC.
        do_reset();
        mem_lat = 1;
        stall   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        check_out("held", 1'b1, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 32'h0);
        check("async_rst req_valid", 32'(imem_req_valid), 32'h0);
        check("async_rst req_addr", imem_req_addr, 32'h0);
        do_reset();
        expect_stream("refetch", 32'h0, 3, 10);

        // PC wrap across 0xFFFF_FFFC.
        do_reset();
        mem_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        advance();
        redirect_valid = 1'b0;
        expect_stream("wrap", 32'hFFFF_FFF8, 4, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
